// File: rtl/tetris_pkg.sv
// tetris_pkg: shared playfield geometry, shape/playfield types, scoring constants and line_clear states
package tetris_pkg;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  typedef struct packed {
    logic [2:0] kind;
    logic [1:0] rot;
    logic [4:0] shape_row_pos;
    logic [3:0] shape_col_pos;
  } shape_t;
  typedef logic [ROWS-1:0][COLS-1:0] playfield_t;
  localparam logic [10:0] PTS_1 = 11'd40;
  localparam logic [10:0] PTS_2 = 11'd100;
  localparam logic [10:0] PTS_3 = 11'd300;
  localparam logic [10:0] PTS_4 = 11'd1200;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} lc_state_e;
  function automatic logic [10:0] points(input int unsigned n);
    return n == 0 ? 11'd0 : n == 1 ? PTS_1 : n == 2 ? PTS_2 : n == 3 ? PTS_3 : PTS_4;
  endfunction
endpackage

// File: rtl/row_collapse.sv
// row_collapse: removes one row from a playfield, shifting upper rows down and zero-filling the top
module row_collapse #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int RW = $clog2(ROWS)
) (
  input  logic [ROWS-1:0][COLS-1:0] field_i,
  input  logic [RW-1:0]             row_i,
  output logic [ROWS-1:0][COLS-1:0] field_o
);
  for (genvar g = 0; g < ROWS; g++) begin : g_row
    if (g == ROWS - 1) begin : g_top
      assign field_o[g] = '0;
    end else begin : g_body
      assign field_o[g] = (row_i > RW'(g)) ? field_i[g] : field_i[g+1];
    end
  end
endmodule

// File: rtl/line_clear.sv
// line_clear: scans a locked playfield, removes full rows one per cycle, publishes result and saturating score
module line_clear #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int SCORE_W = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ROWS-1:0][COLS-1:0] screen_in,
  output logic                      busy,
  output logic                      done,
  output logic [ROWS-1:0][COLS-1:0] screen_out,
  output logic [$clog2(ROWS+1)-1:0] lines_cleared,
  output logic [SCORE_W-1:0]        score
);
  import tetris_pkg::*;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);
  lc_state_e                 state_q, state_d;
  logic [ROWS-1:0][COLS-1:0] work_q, work_d, collapsed;
  logic [RW-1:0]             r_q, r_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [ROWS-1:0][COLS-1:0] out_q, out_d;
  logic [CW-1:0]             lines_q, lines_d;
  logic [SCORE_W-1:0]        score_q, score_d, score_sat;
  logic [SCORE_W:0]          score_sum;
  logic                      full, last;
  row_collapse #(.ROWS(ROWS), .COLS(COLS), .RW(RW)) u_collapse (
    .field_i(work_q),
    .row_i  (r_q),
    .field_o(collapsed)
  );
  assign full      = &work_q[r_q];
  assign last      = r_q == RW'(ROWS - 1);
  assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(points(32'(cnt_q)));
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  // next state: capture on start, collapse or advance in SCAN, publish results when leaving SCAN
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    lines_d = lines_q;
    score_d = score_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SCAN;
        work_d  = screen_in;
        r_d     = '0;
        cnt_d   = '0;
      end
      SCAN: if (full) begin
        work_d = collapsed;
        cnt_d  = cnt_q + CW'(1);
      end else if (last) begin
        state_d = DONE;
        out_d   = work_q;
        lines_d = cnt_q;
        score_d = score_sat;
      end else begin
        r_d = r_q + RW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // state and result registers with synchronous abort on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      lines_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      lines_q <= lines_d;
      score_q <= score_d;
    end
  end
  assign busy          = state_q != IDLE;
  assign done          = state_q == DONE;
  assign screen_out    = out_q;
  assign lines_cleared = lines_q;
  assign score         = score_q;
endmodule

// File: tb/tb_line_clear.sv
// tb_line_clear: directed vector table plus busy, reset-abort and score-saturation sequences
module tb_line_clear;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int SW = 20;
  localparam int CW = 5;
  typedef logic [ROWS-1:0][COLS-1:0] pf_t;
  typedef struct {
    pf_t din;
    pf_t dout;
    int  lines;
    int  lat;
    int  score;
  } vec_t;
  logic          clk = 0;
  logic          reset, start, busy, done;
  pf_t           screen_in, screen_out;
  logic [CW-1:0] lines_cleared;
  logic [SW-1:0] score;
  int            checks = 0;
  int            failures = 0;
  vec_t          v[6];
  line_clear #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .screen_in    (screen_in),
    .busy         (busy),
    .done         (done),
    .screen_out   (screen_out),
    .lines_cleared(lines_cleared),
    .score        (score)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_op(input pf_t pf, output int lat);
    start = 1;
    screen_in = pf;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      #1;
      start = 0;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask
  initial begin
    int  lat, n, seen, s;
    pf_t four;
    reset = 1;
    start = 0;
    screen_in = '0;
    for (int i = 0; i < 6; i++) begin
      v[i].din = '0;
      v[i].dout = '0;
    end
    v[0].lines = 0; v[0].lat = 21; v[0].score = 0;
    v[1].din[0] = 10'h3FF; v[1].din[1] = 10'h001;
    v[1].dout[0] = 10'h001;
    v[1].lines = 1; v[1].lat = 22; v[1].score = 40;
    v[2].din[0] = 10'h3FF; v[2].din[1] = 10'h3FF; v[2].din[2] = 10'h3FF; v[2].din[3] = 10'h155;
    v[2].dout[0] = 10'h155;
    v[2].lines = 3; v[2].lat = 24; v[2].score = 340;
    v[3].din[0] = 10'h3FF; v[3].din[1] = 10'h0F0; v[3].din[2] = 10'h3FF; v[3].din[3] = 10'h00F;
    v[3].dout[0] = 10'h0F0; v[3].dout[1] = 10'h00F;
    v[3].lines = 2; v[3].lat = 23; v[3].score = 440;
    v[4].din = '1;
    v[4].lines = 20; v[4].lat = 41; v[4].score = 1640;
    v[5].din[0] = 10'h123; v[5].din[5] = 10'h3FF; v[5].din[18] = 10'h201; v[5].din[19] = 10'h3FF;
    v[5].dout[0] = 10'h123; v[5].dout[17] = 10'h201;
    v[5].lines = 2; v[5].lat = 23; v[5].score = 1740;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst screen_out", screen_out, 0);
    chk("rst lines", lines_cleared, 0);
    chk("rst score", score, 0);
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].din, lat);
      chk($sformatf("v%0d latency", i), lat, v[i].lat);
      chk($sformatf("v%0d screen_out", i), screen_out, v[i].dout);
      chk($sformatf("v%0d lines", i), lines_cleared, v[i].lines);
      chk($sformatf("v%0d score", i), score, v[i].score);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done pulse", i), done, 0);
    end
    start = 1;
    screen_in = '0;
    screen_in[0] = 10'h3FF;
    screen_in[1] = 10'h2AA;
    @(posedge clk);
    #1;
    start = 0;
    n = 1;
    chk("busy after start", busy, 1);
    repeat (4) @(posedge clk);
    #1;
    n += 4;
    start = 1;
    screen_in = '1;
    @(posedge clk);
    #1;
    start = 0;
    n++;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy-start latency", lat, 22);
    chk("busy-start lines", lines_cleared, 1);
    chk("busy-start row0", screen_out[0], 10'h2AA);
    chk("busy-start score", score, 1780);
    start = 1;
    screen_in = '1;
    @(posedge clk);
    #1;
    start = 0;
    chk("done-start idle1", busy, 0);
    @(posedge clk);
    #1;
    chk("done-start idle2", busy, 0);
    start = 1;
    screen_in = '1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort screen_out", screen_out, 0);
    chk("abort lines", lines_cleared, 0);
    chk("abort score", score, 0);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("abort no done", seen, 0);
    run_op(v[1].din, lat);
    chk("post-abort latency", lat, 22);
    chk("post-abort screen_out", screen_out, v[1].dout);
    chk("post-abort score", score, 40);
    @(posedge clk);
    #1;
    s = 40;
    while (s + 1200 <= 1048575) begin
      run_op('1, lat);
      @(posedge clk);
      #1;
      s += 1200;
    end
    chk("preload score", score, s);
    four = '0;
    for (int i = 0; i < 4; i++) four[i] = 10'h3FF;
    four[4] = 10'h3FE;
    run_op(four, lat);
    chk("sat latency", lat, 25);
    chk("sat lines", lines_cleared, 4);
    chk("sat row0", screen_out[0], 10'h3FE);
    chk("sat score", score, 20'hFFFFF);
    @(posedge clk);
    #1;
    run_op(v[1].din, lat);
    chk("sat hold score", score, 20'hFFFFF);
    chk("sat hold lines", lines_cleared, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
